// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding a single UART TX byte stream from several
// requesters. A grant is held for a whole message and released on the
// last byte, on reaching the burst limit, or after the owner stays idle
// for HOLD_TIMEOUT cycles. Each grant is followed by one IDLE cycle.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 8,
  parameter int MAX_BURST    = 64,
  parameter int HOLD_TIMEOUT = 255
) (
  input  logic                      sys_clk,
  input  logic                      sys_rstn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_valid,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_ready,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BCNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST + 1) : 1;
  localparam int ICNT_W = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT + 1) : 1;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t            state;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  owner;
  logic [BCNT_W-1:0] bcnt;
  logic [ICNT_W-1:0] icnt;

  logic              sel_found;
  logic [IDX_W-1:0]  sel_idx;
  logic              own_valid;
  logic              own_last;
  logic              beat;
  logic              release_now;
  logic [IDX_W-1:0]  ptr_next;

  // Pick the first valid requester at or after ptr, wrapping around.
  // The loop runs from the farthest offset down so the nearest one wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(ptr) + k) % NUM_REQ]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

  // Owner-side datapath: a pure mux from the registered grant, no storage.
  always_comb begin
    own_valid   = req_valid[owner];
    own_last    = req_last[owner];
    tx_data     = req_data[int'(owner)*DATA_W +: DATA_W];
    tx_valid    = |(grant & req_valid);
    req_ready   = grant & {NUM_REQ{tx_ready}};
    beat        = tx_valid & tx_ready;
    release_now = (beat && (own_last || bcnt == BCNT_W'(MAX_BURST - 1))) ||
                  (!own_valid && icnt == ICNT_W'(HOLD_TIMEOUT - 1));
    ptr_next    = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
  end

  // Arbitration FSM with grant, busy, pointer and counters as registered state.
  always_ff @(posedge sys_clk) begin
    if (!sys_rstn) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
      grant <= '0;
      busy  <= 1'b0;
      bcnt  <= '0;
      icnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            state <= GRANT;
            owner <= sel_idx;
            grant <= {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_idx;
            busy  <= 1'b1;
            bcnt  <= '0;
            icnt  <= '0;
          end
        end
        GRANT: begin
          if (release_now) begin
            state <= IDLE;
            ptr   <= ptr_next;
            grant <= '0;
            busy  <= 1'b0;
            bcnt  <= '0;
            icnt  <= '0;
          end else begin
            if (beat) bcnt <= bcnt + 1'b1;
            icnt <= own_valid ? '0 : icnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter. u_dut uses a small burst limit and
// timeout; u_big uses the default limits for the long-message case. Both
// share the same stimulus.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  valid;
  logic [3:0]  last;
  logic        tx_ready;
  logic [7:0]  d0, d1, d2, d3;
  logic [31:0] req_data;

  logic [3:0]  req_ready_s, grant_s;
  logic        tx_valid_s, busy_s;
  logic [7:0]  tx_data_s;
  logic [3:0]  req_ready_b, grant_b;
  logic        tx_valid_b, busy_b;
  logic [7:0]  tx_data_b;

  int ntests = 0;
  int nfail  = 0;
  int b;
  logic tr;

  assign req_data = {d3, d2, d1, d0};

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(4), .HOLD_TIMEOUT(8)) u_dut (
    .sys_clk(clk), .sys_rstn(rstn), .req_valid(valid), .req_data(req_data),
    .req_last(last), .req_ready(req_ready_s), .tx_valid(tx_valid_s),
    .tx_data(tx_data_s), .tx_ready(tx_ready), .grant(grant_s), .busy(busy_s)
  );

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(64), .HOLD_TIMEOUT(255)) u_big (
    .sys_clk(clk), .sys_rstn(rstn), .req_valid(valid), .req_data(req_data),
    .req_last(last), .req_ready(req_ready_b), .tx_valid(tx_valid_b),
    .tx_data(tx_data_b), .tx_ready(tx_ready), .grant(grant_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rstn  = 1'b0;
    valid = 4'b0000;
    last  = 4'b0000;
    tick();
    rstn  = 1'b1;
  endtask

  initial begin
    // Reset held with every requester valid
    rstn = 1'b0; valid = 4'hF; last = 4'hF; tx_ready = 1'b1;
    d0 = 8'hA0; d1 = 8'hA1; d2 = 8'hA2; d3 = 8'hA3;
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk("rst_grant", 32'(grant_s), 32'h0);
      chk("rst_busy", 32'(busy_s), 32'h0);
      chk("rst_tx_valid", 32'(tx_valid_s), 32'h0);
      chk("rst_req_ready", 32'(req_ready_s), 32'h0);
    end
    rstn = 1'b1;
    tick(); #1;
    chk("first_grant", 32'(grant_s), 32'h1);
    chk("first_busy", 32'(busy_s), 32'h1);
    chk("first_data", 32'(tx_data_s), 32'hA0);
    chk("first_ready", 32'(req_ready_s), 32'h1);

    // Round robin over single-byte messages
    for (int i = 1; i <= 4; i++) begin
      tick(); #1;
      chk("rr_idle_grant", 32'(grant_s), 32'h0);
      chk("rr_idle_valid", 32'(tx_valid_s), 32'h0);
      tick(); #1;
      chk("rr_grant", 32'(grant_s), 32'(4'b0001 << (i % 4)));
      chk("rr_data", 32'(tx_data_s), 32'(8'hA0 + (i % 4)));
    end

    // Five-byte message from requester 2 with tx_ready toggling (default limits)
    do_reset();
    valid = 4'b0100; d2 = 8'h11; last = 4'b0000; tx_ready = 1'b0;
    tick(); #1;
    chk("msg_grant", 32'(grant_b), 32'h4);
    valid = 4'b0101; d0 = 8'h55;
    b = 0; tr = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tx_ready = tr;
      d2 = 8'(8'h11 + b);
      last = (b == 4) ? 4'b0100 : 4'b0000;
      #1;
      chk("msg_hold_grant", 32'(grant_b), 32'h4);
      chk("msg_ready", 32'(req_ready_b), tr ? 32'h4 : 32'h0);
      if (tr) begin
        chk("msg_data", 32'(tx_data_b), 32'(8'h11 + b));
        b++;
      end
      tick();
      tr = ~tr;
    end
    valid = 4'b0001; last = 4'b0000; tx_ready = 1'b1;
    #1;
    chk("msg_idle", 32'(grant_b), 32'h0);
    tick(); #1;
    chk("msg_next_grant", 32'(grant_b), 32'h1);
    chk("msg_next_data", 32'(tx_data_b), 32'h55);

    // Burst limit of 4 with requester 3 waiting
    do_reset();
    valid = 4'b0010; d1 = 8'h21; tx_ready = 1'b1;
    tick();
    valid = 4'b1010; d3 = 8'h31; last = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      d1 = 8'(8'h21 + i);
      #1;
      chk("burst_grant", 32'(grant_s), 32'h2);
      chk("burst_data", 32'(tx_data_s), 32'(8'h21 + i));
      tick();
    end
    #1;
    chk("burst_release", 32'(grant_s), 32'h0);
    tick(); #1;
    chk("burst_next_grant", 32'(grant_s), 32'h8);
    chk("burst_next_data", 32'(tx_data_s), 32'h31);
    tick();
    valid = 4'b0010; d1 = 8'h25;
    #1;
    chk("burst_gap", 32'(grant_s), 32'h0);
    tick(); #1;
    chk("burst_resume_grant", 32'(grant_s), 32'h2);
    chk("burst_resume_data", 32'(tx_data_s), 32'h25);

    // Idle timeout of 8 cycles after two bytes
    do_reset();
    valid = 4'b0001; d0 = 8'h41; tx_ready = 1'b1;
    tick(); #1;
    chk("to_grant", 32'(grant_s), 32'h1);
    tick();
    d0 = 8'h42;
    tick();
    valid = 4'b0000;
    for (int j = 1; j <= 8; j++) begin
      #1;
      chk("to_hold", 32'(grant_s), 32'h1);
      chk("to_txv", 32'(tx_valid_s), 32'h0);
      tick();
    end
    #1;
    chk("to_release", 32'(grant_s), 32'h0);
    chk("to_busy", 32'(busy_s), 32'h0);

    // Last and burst limit on the same beat
    do_reset();
    valid = 4'b0100; d2 = 8'h61; tx_ready = 1'b1;
    tick();
    valid = 4'b1101; d0 = 8'h01; d3 = 8'h03;
    for (int i = 0; i < 4; i++) begin
      d2 = 8'(8'h61 + i);
      last = (i == 3) ? 4'b1100 : 4'b1000;
      #1;
      chk("ll_grant", 32'(grant_s), 32'h4);
      chk("ll_data", 32'(tx_data_s), 32'(8'h61 + i));
      tick();
    end
    #1;
    chk("ll_idle", 32'(grant_s), 32'h0);
    chk("ll_idle_busy", 32'(busy_s), 32'h0);
    tick(); #1;
    chk("ll_ptr_next", 32'(grant_s), 32'h8);
    chk("ll_ptr_data", 32'(tx_data_s), 32'h03);

    // Reset in the middle of a message
    do_reset();
    valid = 4'b0100; last = 4'b0100; d2 = 8'h81; tx_ready = 1'b1;
    tick(); #1;
    chk("mr_pre_grant", 32'(grant_s), 32'h4);
    tick();
    valid = 4'b0010; last = 4'b0000; d1 = 8'h71;
    #1;
    chk("mr_pre_idle", 32'(grant_s), 32'h0);
    tick(); #1;
    chk("mr_grant", 32'(grant_s), 32'h2);
    tick();
    d1 = 8'h72;
    tick();
    d1 = 8'h73; rstn = 1'b0;
    #1;
    chk("mr_byte3_valid", 32'(tx_valid_s), 32'h1);
    chk("mr_byte3_data", 32'(tx_data_s), 32'h73);
    tick(); #1;
    chk("mr_txv", 32'(tx_valid_s), 32'h0);
    chk("mr_gnt", 32'(grant_s), 32'h0);
    chk("mr_rdy", 32'(req_ready_s), 32'h0);
    chk("mr_busy", 32'(busy_s), 32'h0);
    rstn = 1'b1; valid = 4'b1010; d3 = 8'h93;
    tick(); #1;
    chk("mr_restart_grant", 32'(grant_s), 32'h2);
    chk("mr_restart_data", 32'(tx_data_s), 32'h73);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
